pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Sequences stalls and flushes for the 5-stage MIPS pipeline around the forwarding/hazard unit.
//  Consumes the hazard unit's load-use bubble request, EX-stage branch resolution, a multi-cycle
//  mult/div start and an external halt. Drives the PC/IF-ID/ID-EX enables and the pipeline flushes.
//  Counts stall cycles for performance monitoring.
// PARAMETERS
//  MD_LAT  4   cycles a mult/div occupies EX, including its first cycle; legal range >= 2
//  CNT_W   16  width of the stall-cycle counter
// PORTS
//  clk          in   1      pipeline clock, rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  load_use     in   1      bubble request from the hazard unit (load in EX feeds instr in ID)
//  branch_taken in   1      EX-stage branch/jump resolved taken
//  md_start     in   1      mult/div instruction present in EX
//  ext_halt     in   1      debug freeze request, level-sensitive
//  stat_clr     in   1      synchronous clear of stall_cnt
//  pc_en        out  1      PC register write enable
//  ifid_en      out  1      IF/ID register enable
//  idex_en      out  1      ID/EX register enable
//  ifid_flush   out  1      zero the IF/ID register (insert nop)
//  idex_flush   out  1      zero the ID/EX register (insert bubble)
//  exmem_flush  out  1      zero the EX/MEM register (insert bubble)
//  md_done      out  1      1-cycle pulse: mult/div result valid; EX advances this cycle
//  state        out  2      00 RUN, 01 MD_WAIT, 10 HALT
//  stall_cnt    out  CNT_W  cycles with pc_en=0, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - state=RUN, saved_state=RUN, md_cnt=0, stall_cnt=0.
//    - Outputs forced: pc_en=ifid_en=idex_en=0; ifid_flush=idex_flush=exmem_flush=1; md_done=0.
//  - Outputs are combinational from the registered state and the current inputs (zero latency).
//  - Default (no event): all enables 1, all flushes 0.
//  - RUN, priority ext_halt > branch_taken > md_start > load_use:
//    - ext_halt: freeze (all enables 0, flushes 0); saved_state<=RUN; next HALT.
//    - branch_taken: ifid_flush=1, idex_flush=1, pc_en=1. load_use is ignored (ID is wrong-path).
//      md_start is ignored; branch_taken with md_start is illegal and branch wins.
//    - md_start: pc_en=ifid_en=idex_en=0, exmem_flush=1; md_cnt<=MD_LAT-2; next MD_WAIT.
//    - load_use: pc_en=0, ifid_en=0, idex_flush=1 for this cycle only; state stays RUN.
//  - MD_WAIT:
//    - md_cnt!=0: same stall outputs as md_start; md_cnt decrements.
//    - md_cnt==0: md_done=1, default outputs; next RUN.
//    - Stall lasts MD_LAT-1 cycles (T..T+MD_LAT-2); md_done at T+MD_LAT-1.
//    - load_use, branch_taken and md_start are ignored in MD_WAIT.
//    - ext_halt has priority: freeze, md_cnt held, saved_state<=MD_WAIT, next HALT, no md_done.
//  - HALT:
//    - Outputs frozen (enables 0, flushes 0, md_done 0) every cycle, including the release cycle.
//    - ext_halt=0: next state=saved_state; md_cnt resumes from its held value.
//  - stall_cnt:
//    - Increments on each post-reset cycle with pc_en=0; saturates at all-ones.
//    - stat_clr sets it to 0 and wins over an increment in the same cycle.
// TESTING
//  1. Release reset, then load_use=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle;
//     stall_cnt=1; state stays 00.
//  2. md_start=1 at cycle T (MD_LAT=4) -> stall outputs at T,T+1,T+2; md_done=1 at T+3;
//     state 01 at T+1..T+3; 00 at T+4; stall_cnt=3.
//  3. branch_taken=1 and load_use=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1;
//     stall_cnt unchanged.
//  4. ext_halt at T+1 of a mult/div, held for 5 cycles -> state 10 for 5 cycles, outputs frozen;
//     after release, 01 resumes with the held md_cnt; md_done arrives 6 cycles later than in test 2.
//  5. CNT_W=4: hold ext_halt for 20 cycles -> stall_cnt saturates at 15;
//     stat_clr then gives 0 on the next cycle.
//  6. Assert rst_n=0 mid-MD_WAIT -> outputs immediately forced to reset values; after release,
//     state=00, md_done never pulses.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It takes the hazard unit's load-use bubble, EX branch resolution, multi-cycle
// mult/div occupancy and debug halt, and turns them into PC/IF-ID/ID-EX enables
// and pipeline flushes. It also counts the cycles in which the PC is held.
module pipeline_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             ext_halt,
    input  logic             stat_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_done,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_WAIT = 2'b01,
        HALT    = 2'b10
    } state_t;

    // The counter holds the remaining stall cycles after the first one, so it
    // must be able to hold MD_LAT-2.
    localparam int              MD_W    = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LAT - 2);

    state_t          cur;
    state_t          saved;
    logic [MD_W-1:0] md_cnt;

    assign state = cur;

    // Output decode from the registered state and the live inputs. While reset
    // is asserted, the enables drop and every flush asserts, so the pipeline is
    // filled with bubbles.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_done     = 1'b0;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (cur)
                RUN: begin
                    if (ext_halt) begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                        idex_en = 1'b0;
                    end else if (branch_taken) begin
                        // Squash the wrong-path instructions in IF and ID.
                        // Any load-use request comes from the wrong path.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (md_start) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (ext_halt) begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                        idex_en = 1'b0;
                    end else if (md_cnt != '0) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                    end else begin
                        md_done = 1'b1;
                    end
                end
                HALT: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // State machine, mult/div countdown and the saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= RUN;
            saved     <= RUN;
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (stat_clr)
                stall_cnt <= '0;
            else if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);

            case (cur)
                RUN: begin
                    if (ext_halt) begin
                        saved <= RUN;
                        cur   <= HALT;
                    end else if (!branch_taken && md_start) begin
                        md_cnt <= MD_INIT;
                        cur    <= MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    // A halt freezes the countdown so the operation resumes intact.
                    if (ext_halt) begin
                        saved <= MD_WAIT;
                        cur   <= HALT;
                    end else if (md_cnt != '0) begin
                        md_cnt <= md_cnt - MD_W'(1);
                    end else begin
                        cur <= RUN;
                    end
                end
                HALT: begin
                    if (!ext_halt)
                        cur <= saved;
                end
                default: cur <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl.
// A table of per-cycle vectors covers load-use, mult/div, branch and halt
// sequencing. Hand-written sequences then cover counter saturation and reset
// asserted in the middle of a mult/div.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use, branch_taken, md_start, ext_halt, stat_clr;
    logic        pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_done;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_ifid_flush, s_idex_flush, s_exmem_flush, s_md_done;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MD_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
        .md_start(md_start), .ext_halt(ext_halt), .stat_clr(stat_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .md_done(md_done), .state(state), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy, used for the saturation check.
    pipeline_stall_ctrl #(.MD_LAT(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
        .md_start(md_start), .ext_halt(ext_halt), .stat_clr(stat_clr),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .md_done(s_md_done), .state(s_state), .stall_cnt(s_stall_cnt)
    );

    // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_done}
    localparam logic [6:0] O_DEF  = 7'b111_000_0;
    localparam logic [6:0] O_LU   = 7'b001_010_0;
    localparam logic [6:0] O_BR   = 7'b111_110_0;
    localparam logic [6:0] O_MD   = 7'b000_001_0;
    localparam logic [6:0] O_DONE = 7'b111_000_1;
    localparam logic [6:0] O_FRZ  = 7'b000_000_0;
    localparam logic [6:0] O_RST  = 7'b000_111_0;

    // Input bits: {load_use, branch_taken, md_start, ext_halt, stat_clr}
    localparam logic [4:0] I_NONE = 5'b00000;
    localparam logic [4:0] I_LU   = 5'b10000;
    localparam logic [4:0] I_BR   = 5'b01000;
    localparam logic [4:0] I_MD   = 5'b00100;
    localparam logic [4:0] I_EH   = 5'b00010;
    localparam logic [4:0] I_CLR  = 5'b00001;

    typedef struct {
        logic [4:0] in;
        logic [6:0] out;
        logic [1:0] st;
        int         cnt;   // stall_cnt seen during the cycle, before its edge
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] outs();
        return {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_done};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] in, input logic [6:0] out, input logic [1:0] st, input int cnt);
        vec_t v;
        v.in = in; v.out = out; v.st = st; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] in);
        {load_use, branch_taken, md_start, ext_halt, stat_clr} = in;
    endtask

    initial begin
        // Cycle-by-cycle expectations; state 00 RUN, 01 MD_WAIT, 10 HALT.
        add(I_NONE,        O_DEF,  2'b00, 0);
        add(I_LU,          O_LU,   2'b00, 0);   // single load-use bubble
        add(I_NONE,        O_DEF,  2'b00, 1);
        add(I_MD,          O_MD,   2'b00, 1);   // mult/div at T
        add(I_NONE,        O_MD,   2'b01, 2);
        add(I_LU | I_BR,   O_MD,   2'b01, 3);   // ignored while waiting
        add(I_NONE,        O_DONE, 2'b01, 4);   // md_done at T+3
        add(I_NONE,        O_DEF,  2'b00, 4);
        add(I_BR | I_LU,   O_BR,   2'b00, 4);   // branch beats load-use
        add(I_NONE,        O_DEF,  2'b00, 4);
        add(I_CLR,         O_DEF,  2'b00, 4);
        add(I_MD,          O_MD,   2'b00, 0);   // T
        add(I_EH,          O_FRZ,  2'b01, 1);   // halt at T+1
        add(I_EH,          O_FRZ,  2'b10, 2);
        add(I_EH,          O_FRZ,  2'b10, 3);
        add(I_EH,          O_FRZ,  2'b10, 4);
        add(I_EH,          O_FRZ,  2'b10, 5);
        add(I_NONE,        O_FRZ,  2'b10, 6);   // release cycle still frozen
        add(I_NONE,        O_MD,   2'b01, 7);   // resumes with held count
        add(I_NONE,        O_MD,   2'b01, 8);
        add(I_NONE,        O_DONE, 2'b01, 9);   // T+9: six cycles later
        add(I_NONE,        O_DEF,  2'b00, 9);
        add(I_EH | I_BR,   O_FRZ,  2'b00, 9);   // halt beats branch
        add(I_NONE,        O_FRZ,  2'b10, 10);
        add(I_MD | I_LU,   O_MD,   2'b00, 11);  // returned to RUN; md beats lu
        add(I_NONE,        O_MD,   2'b01, 12);
        add(I_MD,          O_MD,   2'b01, 13);  // md_start ignored in MD_WAIT
        add(I_MD,          O_DONE, 2'b01, 14);
        add(I_NONE,        O_DEF,  2'b00, 14);

        // Reset state
        rst_n = 1'b0;
        drive(I_NONE);
        #12;
        chk("reset outs", 32'(outs()), 32'(O_RST));
        chk("reset state", 32'(state), 32'd0);
        chk("reset cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            #1;
            chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(vecs[i].out));
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d cnt", i), 32'(stall_cnt), 32'(vecs[i].cnt));
            @(posedge clk); #1;
        end

        // Saturation of the 4-bit counter under a long halt
        drive(I_CLR);
        @(posedge clk); #1;
        drive(I_EH);
        #1;
        chk("sat start cnt4", 32'(s_stall_cnt), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("sat cnt4", 32'(s_stall_cnt), 32'd15);
        chk("sat cnt16", 32'(stall_cnt), 32'd20);
        chk("sat state", 32'(state), 32'd2);
        drive(I_CLR);
        #1;
        chk("sat release pc_en", 32'(pc_en), 32'd0);
        @(posedge clk); #1;
        drive(I_NONE);
        #1;
        chk("clr cnt4", 32'(s_stall_cnt), 32'd0);
        chk("clr cnt16", 32'(stall_cnt), 32'd0);
        chk("clr state", 32'(state), 32'd0);

        // Reset in the middle of a mult/div
        drive(I_MD);
        @(posedge clk); #1;
        drive(I_NONE);
        #1;
        chk("pre-rst state", 32'(state), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst outs", 32'(outs()), 32'(O_RST));
        chk("mid-rst state", 32'(state), 32'd0);
        chk("mid-rst cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("post-rst%0d md_done", c), 32'(md_done), 32'd0);
            chk($sformatf("post-rst%0d state", c), 32'(state), 32'd0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
